// File: rtl/sistema_ram_arbiter.sv
// Two-master round-robin arbiter in front of a single-port 32-bit on-chip RAM.
// Grant is combinational; read data is routed back to its issuer one cycle later.
module sistema_ram_arbiter #(
    parameter int DEPTH = 40000,
    parameter int AW    = 16,
    parameter int DW    = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [AW-1:0]     m0_address,
    input  logic [DW/8-1:0]   m0_byteenable,
    input  logic [DW-1:0]     m0_writedata,
    output logic              m0_waitrequest,
    output logic [DW-1:0]     m0_readdata,
    output logic              m0_readdatavalid,
    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [AW-1:0]     m1_address,
    input  logic [DW/8-1:0]   m1_byteenable,
    input  logic [DW-1:0]     m1_writedata,
    output logic              m1_waitrequest,
    output logic [DW-1:0]     m1_readdata,
    output logic              m1_readdatavalid,
    output logic [AW-1:0]     ram_address,
    output logic [DW/8-1:0]   ram_byteenable,
    output logic [DW-1:0]     ram_writedata,
    output logic              ram_chipselect,
    output logic              ram_write,
    output logic              ram_clken,
    input  logic [DW-1:0]     ram_readdata,
    output logic              err_sticky,
    input  logic              err_clear
);

    localparam int BW = DW / 8;
    localparam logic [AW:0] DEPTH_L = (AW + 1)'(DEPTH);

    typedef enum logic {
        MST0 = 1'b0,
        MST1 = 1'b1
    } mst_e;

    function automatic logic addr_in_range(input logic [AW-1:0] addr);
        return ({1'b0, addr} < DEPTH_L);
    endfunction

    logic            req0_s, req1_s;
    logic            gnt0_s, gnt1_s;
    logic            accepted_s;
    logic            sel_read_s, sel_write_s;
    logic [AW-1:0]   sel_addr_s;
    logic [BW-1:0]   sel_be_s;
    logic [DW-1:0]   sel_wdata_s;
    logic            in_range_s;
    logic            err_set_s;

    mst_e            last_grant_q, last_grant_d;
    logic            rd_pend_q, rd_pend_d;
    mst_e            rd_owner_q, rd_owner_d;
    logic            rd_oor_q, rd_oor_d;
    logic            err_sticky_q, err_sticky_d;

    // Round-robin grant: on a tie the master not granted last time wins.
    always_comb begin
        req0_s = m0_read | m0_write;
        req1_s = m1_read | m1_write;
        gnt0_s = 1'b0;
        gnt1_s = 1'b0;
        if (reset) begin
            gnt0_s = 1'b0;
            gnt1_s = 1'b0;
        end else begin
            case ({req0_s, req1_s})
                2'b10: gnt0_s = 1'b1;
                2'b01: gnt1_s = 1'b1;
                2'b11: begin
                    if (last_grant_q == MST1) begin
                        gnt0_s = 1'b1;
                    end else begin
                        gnt1_s = 1'b1;
                    end
                end
                default: begin
                    gnt0_s = 1'b0;
                    gnt1_s = 1'b0;
                end
            endcase
        end
        accepted_s = gnt0_s | gnt1_s;
    end

    // Granted-master mux; everything is zero when nobody holds the grant.
    always_comb begin
        sel_read_s  = 1'b0;
        sel_write_s = 1'b0;
        sel_addr_s  = {AW{1'b0}};
        sel_be_s    = {BW{1'b0}};
        sel_wdata_s = {DW{1'b0}};
        if (gnt1_s) begin
            sel_read_s  = m1_read;
            sel_write_s = m1_write;
            sel_addr_s  = m1_address;
            sel_be_s    = m1_byteenable;
            sel_wdata_s = m1_writedata;
        end else if (gnt0_s) begin
            sel_read_s  = m0_read;
            sel_write_s = m0_write;
            sel_addr_s  = m0_address;
            sel_be_s    = m0_byteenable;
            sel_wdata_s = m0_writedata;
        end else begin
            sel_read_s  = 1'b0;
            sel_write_s = 1'b0;
        end
        in_range_s = addr_in_range(sel_addr_s);
    end

    // RAM port drive; read+write together is handled as a write.
    always_comb begin
        ram_address    = sel_addr_s;
        ram_byteenable = sel_be_s;
        ram_writedata  = sel_wdata_s;
        ram_chipselect = accepted_s & in_range_s;
        ram_write      = accepted_s & sel_write_s & in_range_s;
        ram_clken      = 1'b1;
    end

    // Next-state for grant history, read-return tracking and the error flag.
    always_comb begin
        last_grant_d = last_grant_q;
        rd_owner_d   = rd_owner_q;
        rd_oor_d     = rd_oor_q;
        rd_pend_d    = accepted_s & sel_read_s & ~sel_write_s;
        err_set_s    = accepted_s & (~in_range_s | (sel_read_s & sel_write_s));
        if (accepted_s) begin
            last_grant_d = gnt1_s ? MST1 : MST0;
        end else begin
            last_grant_d = last_grant_q;
        end
        if (rd_pend_d) begin
            rd_owner_d = gnt1_s ? MST1 : MST0;
            rd_oor_d   = ~in_range_s;
        end else begin
            rd_owner_d = rd_owner_q;
            rd_oor_d   = rd_oor_q;
        end
        if (err_set_s) begin
            err_sticky_d = 1'b1;
        end else if (err_clear) begin
            err_sticky_d = 1'b0;
        end else begin
            err_sticky_d = err_sticky_q;
        end
    end

    // State registers; reset drops any read still in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_grant_q <= MST1;
            rd_pend_q    <= 1'b0;
            rd_owner_q   <= MST0;
            rd_oor_q     <= 1'b0;
            err_sticky_q <= 1'b0;
        end else begin
            last_grant_q <= last_grant_d;
            rd_pend_q    <= rd_pend_d;
            rd_owner_q   <= rd_owner_d;
            rd_oor_q     <= rd_oor_d;
            err_sticky_q <= err_sticky_d;
        end
    end

    // Master-side handshake and read-data return.
    always_comb begin
        m0_waitrequest   = reset | (req0_s & ~gnt0_s);
        m1_waitrequest   = reset | (req1_s & ~gnt1_s);
        m0_readdatavalid = rd_pend_q & (rd_owner_q == MST0);
        m1_readdatavalid = rd_pend_q & (rd_owner_q == MST1);
        if (m0_readdatavalid & ~rd_oor_q) begin
            m0_readdata = ram_readdata;
        end else begin
            m0_readdata = {DW{1'b0}};
        end
        if (m1_readdatavalid & ~rd_oor_q) begin
            m1_readdata = ram_readdata;
        end else begin
            m1_readdata = {DW{1'b0}};
        end
        err_sticky = err_sticky_q;
    end

endmodule

// File: tb/tb_sistema_ram_arbiter.sv
// Bench for sistema_ram_arbiter: directed scenarios then randomized traffic,
// each cycle compared against a transaction-level model of arbitration and RAM.
module tb_sistema_ram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [15:0] m0_address, m1_address;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic [31:0] m0_writedata, m1_writedata;
    logic        err_clear;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic [15:0] ram_address;
    logic [3:0]  ram_byteenable;
    logic [31:0] ram_writedata;
    logic        ram_chipselect, ram_write, ram_clken, err_sticky;
    logic [31:0] ram_rdata = 32'h0;

    bit [31:0]   ram_mem [40000];
    bit [31:0]   ref_mem [40000];

    int          lg, owner;
    bit          pend, err_q;
    logic [31:0] pend_data;
    int          n_vec, n_err, cyc, run0, run1;
    bit          acc0, acc1;
    logic        s_valid0, s_valid1, s_cs, s_we, s_err, s_wait0, s_wait1;
    logic [31:0] s_rdata0, s_rdata1;

    typedef struct {
        bit          busy;
        bit          rd;
        bit          wr;
        logic [15:0] a;
        logic [3:0]  be;
        logic [31:0] d;
    } req_t;
    req_t q0, q1;

    sistema_ram_arbiter dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_address(m0_address),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_read(m1_read), .m1_write(m1_write), .m1_address(m1_address),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .ram_address(ram_address), .ram_byteenable(ram_byteenable),
        .ram_writedata(ram_writedata), .ram_chipselect(ram_chipselect),
        .ram_write(ram_write), .ram_clken(ram_clken), .ram_readdata(ram_rdata),
        .err_sticky(err_sticky), .err_clear(err_clear)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] lane_merge(input logic [31:0] old_w, input logic [31:0] new_w,
                                               input logic [3:0] be);
        logic [31:0] r;
        r = old_w;
        for (int b = 0; b < 4; b++) begin
            if (be[b]) r[8*b +: 8] = new_w[8*b +: 8];
        end
        return r;
    endfunction

    // Behavioural single-port RAM with one cycle of read latency.
    always @(posedge clk) begin
        if (ram_chipselect) begin
            if (ram_write) ram_mem[ram_address] <= lane_merge(ram_mem[ram_address], ram_writedata, ram_byteenable);
            else           ram_rdata <= ram_mem[ram_address];
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cycle=%0d observed=%h expected=%h", tag, cyc, obs, exp);
        end
    endtask

    // One clock of the reference model: check outputs, then advance state.
    task automatic cycle();
        int          g;
        bit          r0, r1, rd, wr, inr, ill;
        logic [15:0] a;
        logic [3:0]  be;
        logic [31:0] wd, mask;
        logic        e_w0, e_w1, e_v0, e_v1, e_err;
        logic [31:0] e_r0, e_r1;
        #4;
        g = -1; rd = 0; wr = 0; ill = 0; inr = 0; a = 16'h0; be = 4'h0; wd = 32'h0;
        if (reset) begin
            e_w0 = 1; e_w1 = 1; e_v0 = 0; e_v1 = 0; e_r0 = 0; e_r1 = 0; e_err = 0;
        end else begin
            r0 = m0_read | m0_write;
            r1 = m1_read | m1_write;
            if (r0 && r1) g = (lg == 0) ? 1 : 0;
            else if (r0)  g = 0;
            else if (r1)  g = 1;
            e_w0 = r0 && (g != 0);
            e_w1 = r1 && (g != 1);
            e_v0 = pend && (owner == 0);
            e_v1 = pend && (owner == 1);
            e_r0 = e_v0 ? pend_data : 32'h0;
            e_r1 = e_v1 ? pend_data : 32'h0;
            e_err = err_q;
        end
        if (g == 0) begin
            a = m0_address; be = m0_byteenable; wd = m0_writedata;
            wr = m0_write; rd = m0_read && !m0_write; ill = m0_read && m0_write;
        end else if (g == 1) begin
            a = m1_address; be = m1_byteenable; wd = m1_writedata;
            wr = m1_write; rd = m1_read && !m1_write; ill = m1_read && m1_write;
        end
        inr = (g >= 0) && (int'(a) < 40000);
        chk("wait_m0", 32'(m0_waitrequest), 32'(e_w0));
        chk("wait_m1", 32'(m1_waitrequest), 32'(e_w1));
        chk("ram_addr", 32'(ram_address), 32'(a));
        chk("ram_be", 32'(ram_byteenable), 32'(be));
        chk("ram_wdata", ram_writedata, wd);
        chk("ram_cs", 32'(ram_chipselect), 32'(inr));
        chk("ram_we", 32'(ram_write), 32'(wr && inr));
        chk("ram_clken", 32'(ram_clken), 32'd1);
        chk("rvalid_m0", 32'(m0_readdatavalid), 32'(e_v0));
        chk("rvalid_m1", 32'(m1_readdatavalid), 32'(e_v1));
        chk("rdata_m0", m0_readdata, e_r0);
        chk("rdata_m1", m1_readdata, e_r1);
        chk("err_sticky", 32'(err_sticky), 32'(e_err));
        if (!reset) begin
            run0 = m0_waitrequest ? run0 + 1 : 0;
            run1 = m1_waitrequest ? run1 + 1 : 0;
            chk("starve_m0", 32'(run0 <= 1), 32'd1);
            chk("starve_m1", 32'(run1 <= 1), 32'd1);
        end else begin
            run0 = 0; run1 = 0;
        end
        s_valid0 = m0_readdatavalid; s_valid1 = m1_readdatavalid;
        s_rdata0 = m0_readdata; s_rdata1 = m1_readdata;
        s_cs = ram_chipselect; s_we = ram_write; s_err = err_sticky;
        s_wait0 = m0_waitrequest; s_wait1 = m1_waitrequest;
        @(posedge clk);
        if (reset) begin
            lg = 1; pend = 0; owner = 0; err_q = 0;
        end else begin
            if ((g >= 0) && (!inr || ill)) err_q = 1;
            else if (err_clear)             err_q = 0;
            pend = (g >= 0) && rd;
            if (pend) begin
                owner = g;
                pend_data = inr ? ref_mem[a] : 32'h0;
            end
            if ((g >= 0) && wr && inr) begin
                mask = {{8{be[3]}}, {8{be[2]}}, {8{be[1]}}, {8{be[0]}}};
                ref_mem[a] = (ref_mem[a] & ~mask) | (wd & mask);
            end
            if (g >= 0) lg = g;
        end
        acc0 = (g == 0);
        acc1 = (g == 1);
        cyc++;
        #1;
    endtask

    task automatic idle();
        m0_read = 0; m0_write = 0; m1_read = 0; m1_write = 0;
        m0_address = 16'h0; m1_address = 16'h0; m0_byteenable = 4'h0; m1_byteenable = 4'h0;
        m0_writedata = 32'h0; m1_writedata = 32'h0;
    endtask

    task automatic set_m0(input bit rd, input bit wr, input logic [15:0] a, input logic [3:0] be,
                          input logic [31:0] d);
        m0_read = rd; m0_write = wr; m0_address = a; m0_byteenable = be; m0_writedata = d;
    endtask

    task automatic set_m1(input bit rd, input bit wr, input logic [15:0] a, input logic [3:0] be,
                          input logic [31:0] d);
        m1_read = rd; m1_write = wr; m1_address = a; m1_byteenable = be; m1_writedata = d;
    endtask

    function automatic logic [15:0] rnd_addr();
        int k;
        k = $urandom_range(0, 99);
        if (k < 70)      return 16'($urandom_range(0, 63));
        else if (k < 85) return 16'($urandom_range(39990, 40010));
        else             return 16'($urandom);
    endfunction

    function automatic req_t mk_req();
        req_t r;
        int   k;
        k = $urandom_range(0, 99);
        r.busy = 1;
        r.rd = (k < 47) || (k >= 95);
        r.wr = (k >= 47);
        r.a = rnd_addr();
        r.be = 4'($urandom);
        r.d = $urandom;
        return r;
    endfunction

    task automatic drive_rand();
        m0_read = q0.busy & q0.rd; m0_write = q0.busy & q0.wr;
        m0_address = q0.busy ? q0.a : 16'($urandom);
        m0_byteenable = q0.busy ? q0.be : 4'($urandom);
        m0_writedata = q0.busy ? q0.d : $urandom;
        m1_read = q1.busy & q1.rd; m1_write = q1.busy & q1.wr;
        m1_address = q1.busy ? q1.a : 16'($urandom);
        m1_byteenable = q1.busy ? q1.be : 4'($urandom);
        m1_writedata = q1.busy ? q1.d : $urandom;
    endtask

    task automatic rand_phase(input int n, input int pct, input bit with_reset);
        for (int i = 0; i < n; i++) begin
            if (!q0.busy && ($urandom_range(0, 99) < pct)) q0 = mk_req();
            if (!q1.busy && ($urandom_range(0, 99) < pct)) q1 = mk_req();
            drive_rand();
            err_clear = ($urandom_range(0, 9) == 0);
            reset = with_reset && ($urandom_range(0, 99) == 0);
            cycle();
            if (acc0) q0.busy = 0;
            if (acc1) q1.busy = 0;
        end
        reset = 0; err_clear = 0;
    endtask

    initial begin
        n_vec = 0; n_err = 0; cyc = 0; run0 = 0; run1 = 0;
        lg = 1; pend = 0; owner = 0; err_q = 0; pend_data = 32'h0;
        q0.busy = 0; q1.busy = 0;
        reset = 1; err_clear = 0;
        idle();
        repeat (2) @(posedge clk);
        #1;
        cycle(); cycle();
        reset = 0;

        // Single master write then read-back.
        set_m0(0, 1, 16'd5, 4'hF, 32'hDEADBEEF); cycle();
        chk("d1_we", 32'(s_we), 32'd1);
        chk("d1_wait", 32'(s_wait0), 32'd0);
        set_m0(1, 0, 16'd5, 4'hF, 32'h0); cycle();
        chk("d1_we_off", 32'(s_we), 32'd0);
        idle(); cycle();
        chk("d1_valid0", 32'(s_valid0), 32'd1);
        chk("d1_rdata0", s_rdata0, 32'hDEADBEEF);
        chk("d1_valid1", 32'(s_valid1), 32'd0);
        idle(); cycle();
        chk("d1_valid0_once", 32'(s_valid0), 32'd0);

        // Preload addr 1/2, reset, then tied reads alternate starting with m0.
        set_m0(0, 1, 16'd1, 4'hF, 32'hA1A10001); cycle();
        idle(); set_m1(0, 1, 16'd2, 4'hF, 32'hB2B20002); cycle();
        idle(); reset = 1; cycle(); reset = 0;
        set_m0(1, 0, 16'd1, 4'hF, 32'h0); set_m1(1, 0, 16'd2, 4'hF, 32'h0);
        for (int i = 0; i < 4; i++) begin
            cycle();
            chk("d2_wait1", 32'(s_wait1), 32'(i % 2 == 0));
            chk("d2_wait0", 32'(s_wait0), 32'(i % 2 == 1));
            if (i == 1) chk("d2_rdata0", s_rdata0, 32'hA1A10001);
            if (i == 2) chk("d2_rdata1", s_rdata1, 32'hB2B20002);
        end
        idle(); cycle();

        // Byte-lane write.
        set_m1(0, 1, 16'd9, 4'hF, 32'h11223344); cycle();
        set_m1(0, 1, 16'd9, 4'h2, 32'hAABBCCDD); cycle();
        set_m1(1, 0, 16'd9, 4'hF, 32'h0); cycle();
        idle(); cycle();
        chk("d3_rdata1", s_rdata1, 32'h1122CC44);

        // Out of range write and read, then clear the error.
        set_m0(0, 1, 16'd40000, 4'hF, 32'h12345678); cycle();
        chk("d4_cs_wr", 32'(s_cs), 32'd0);
        set_m0(1, 0, 16'hFFFF, 4'hF, 32'h0); cycle();
        chk("d4_cs_rd", 32'(s_cs), 32'd0);
        idle(); cycle();
        chk("d4_valid0", 32'(s_valid0), 32'd1);
        chk("d4_rdata0", s_rdata0, 32'h0);
        chk("d4_err", 32'(s_err), 32'd1);
        err_clear = 1; cycle(); err_clear = 0;
        cycle();
        chk("d4_err_clr", 32'(s_err), 32'd0);

        // Reset while a read is returning.
        set_m0(1, 0, 16'd5, 4'hF, 32'h0); cycle();
        set_m1(1, 0, 16'd2, 4'hF, 32'h0); reset = 1; cycle();
        chk("d5_valid0", 32'(s_valid0), 32'd0);
        chk("d5_wait0", 32'(s_wait0), 32'd1);
        chk("d5_wait1", 32'(s_wait1), 32'd1);
        cycle(); reset = 0; cycle();
        chk("d5_rel_valid0", 32'(s_valid0), 32'd0);
        chk("d5_rel_wait0", 32'(s_wait0), 32'd0);
        chk("d5_rel_wait1", 32'(s_wait1), 32'd1);
        idle(); cycle(); cycle();

        // Illegal read+write behaves as a write.
        set_m1(1, 1, 16'd3, 4'hF, 32'h5); cycle();
        chk("d6_we", 32'(s_we), 32'd1);
        idle(); cycle();
        chk("d6_valid1", 32'(s_valid1), 32'd0);
        chk("d6_err", 32'(s_err), 32'd1);
        set_m0(1, 0, 16'd3, 4'hF, 32'h0); cycle();
        idle(); cycle();
        chk("d6_rdata0", s_rdata0, 32'h5);

        rand_phase(600, 60, 1);
        rand_phase(150, 100, 0);
        idle(); cycle(); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/sistema_ram_arbiter.md
Name: sistema_ram_arbiter

Overview:
- Two-master round-robin arbiter for the single-port 32-bit on-chip RAM. RAM geometry: 40000 words, 16-bit word address, byte enables, 1-cycle read latency, unregistered output.
- Sits between two Avalon-MM masters (CPU data master, DMA/peripheral master) and the RAM slave port.
- Serialises accesses, returns read data to the master that issued the read, and flags out-of-range or illegal accesses.

Parameters:
- DEPTH, 40000, number of valid RAM words; addresses >= DEPTH are out of range.
- AW, 16, word-address width.
- DW, 32, data width; byte-enable width is DW/8.

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous active-high reset
- m0_read, m0_write  in  1 each  master 0 requests
- m0_address  in  AW  master 0 word address
- m0_byteenable  in  DW/8  master 0 byte enables
- m0_writedata  in  DW  master 0 write data
- m0_waitrequest  out  1  master 0 stall
- m0_readdata  out  DW  master 0 read data
- m0_readdatavalid  out  1  master 0 read-data strobe
- m1_*  same set and directions as m0_*, for master 1
- ram_address  out  AW  to RAM
- ram_byteenable  out  DW/8  to RAM
- ram_writedata  out  DW  to RAM
- ram_chipselect  out  1  to RAM
- ram_write  out  1  to RAM
- ram_clken  out  1  RAM clock enable; constant 1
- ram_readdata  in  DW  from RAM, valid the cycle after the read address is presented
- err_sticky  out  1  set on any out-of-range or illegal access
- err_clear  in  1  synchronous clear of err_sticky

Behaviour:
- Request definitions: reqN = mN_read | mN_write. A master holds its request and signals stable until sampled with mN_waitrequest=0.
- Grant (combinational, same cycle):
  - Only one master requests: it is granted.
  - Both request: the master not in last_grant is granted.
  - last_grant is a register, reset value 1, so m0 wins the first tie.
  - last_grant updates to the granted master on every accepted transfer.
- Handshake: mN_waitrequest = reqN & ~grantN. While reset is asserted, both waitrequests = 1.
- Accepted transfer = granted request, 0 wait states. One transfer is accepted per cycle at most; back-to-back transfers are allowed.
- RAM drive (combinational from the granted master):
  - ram_address, ram_byteenable and ram_writedata come from the granted master.
  - ram_chipselect = accepted & in-range.
  - ram_write = accepted & write & in-range.
  - With no grant, all RAM outputs except ram_clken are 0.
- Read return:
  - Registered flags rd_pend and rd_owner capture each accepted read.
  - In the next cycle, mN_readdatavalid=1 for the owner only, and mN_readdata = ram_readdata.
  - If that read was out of range, readdata = 0 (RAM not selected) and valid is still asserted.
  - A read accepted while a previous read returns is legal; the pipeline depth is 1.
  - mN_readdata = 0 when not valid.
- Out of range (address >= DEPTH):
  - Write is dropped (no RAM write) and still completes with waitrequest=0.
  - Read returns 0.
  - Both cases set err_sticky.
- Illegal (read and write asserted together): treated as a write and sets err_sticky.
- err_sticky:
  - Set has priority over err_clear in the same cycle.
  - Reset value 0.
- Reset values: last_grant=1, rd_pend=0, rd_owner=0, err_sticky=0, both readdatavalid=0, both readdata=0.
- Reset mid-operation: a pending read is discarded and no readdatavalid follows reset release. Requests held across reset are re-arbitrated from the last_grant reset value.
- Starvation bound: with both masters requesting continuously, grants alternate every cycle. No master waits more than 1 cycle.

Test Plan:
- Single master: m0 writes 0xDEADBEEF to addr 5 with byteenable 0xF, then reads addr 5 -> ram_write pulses 1 cycle, waitrequest stays 0, m0_readdatavalid=1 exactly 1 cycle after acceptance with readdata 0xDEADBEEF, m1_readdatavalid stays 0.
- Simultaneous reads after reset: m0 reads addr 1, m1 reads addr 2 for 4 cycles -> grant order m0,m1,m0,m1; each readdatavalid arrives for the correct owner with that word's data; m1_waitrequest=1 in cycle 0.
- Byte lanes: m1 writes 0x11223344 to addr 9, then writes 0xAABBCCDD with byteenable 0x2, then reads -> 0x1122CC44.
- Out of range: m0 writes addr 40000, then reads addr 65535 -> no ram_chipselect, read returns 0 with valid, err_sticky=1; pulse err_clear -> 0 next cycle.
- Reset mid-read: assert reset the cycle after m0 read acceptance -> no readdatavalid after release, waitrequests=1 during reset, next tie granted to m0.
- Illegal access: m1 asserts read and write to addr 3 with data 0x5 -> write performed, no readdatavalid, err_sticky=1.
